// File: rtl/datapath_ctrl.sv
// datapath_ctrl: sequencer for the 4-lane datapath vector unit.
//
// Runs one fixed job per start: load A (4 beats), load B (4 beats), multiply
// (save_c + en_a per lane, MUL_WAIT idle cycles after each), load add1
// (4 beats), optional ADD2 sweep, write F sweep, then a one-cycle done pulse.
// All datapath strobes and din are registered; a beat accepted at edge N shows
// up as din + lane enable in the cycle after edge N.
//
// Configuration macro: DPCTRL_ADD2_EN
//   defined   - ADD2 phase runs between LOAD_ADD1 and WRITE.
//   undefined - ADD2 phase removed, en_add2_1..4 tied to 0.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             begin a job, sampled only in IDLE
//   abort             synchronous abort back to IDLE, highest priority
//   s_valid, s_data   operand stream beat (signed, DATA_W bits)
//   s_ready           high in the load states unless abort is asserted
//   din               registered operand to the datapath
//   en_a*, en_b*, en_add1_*, en_add2_*, en_f*   one-cycle lane strobes
//   save_c            one-cycle multiply-capture strobe
//   busy              high whenever not IDLE
//   done              one-cycle job-complete pulse
//   lane              current lane index (debug)
module datapath_ctrl #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MUL_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [DATA_W-1:0] din,
  output logic              en_a1,
  output logic              en_a2,
  output logic              en_a3,
  output logic              en_a4,
  output logic              en_b1,
  output logic              en_b2,
  output logic              en_b3,
  output logic              en_b4,
  output logic              en_add1_1,
  output logic              en_add1_2,
  output logic              en_add1_3,
  output logic              en_add1_4,
  output logic              en_add2_1,
  output logic              en_add2_2,
  output logic              en_add2_3,
  output logic              en_add2_4,
  output logic              en_f1,
  output logic              en_f2,
  output logic              en_f3,
  output logic              en_f4,
  output logic              save_c,
  output logic              busy,
  output logic              done,
  output logic [1:0]        lane
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StMul,
    StLoadAdd1,
    StAdd2,
    StWrite,
    StDone
  } state_e;

  localparam logic [2:0] MulWaitC = 3'(MUL_WAIT);

  state_e             state_q, state_d;
  logic [1:0]         lane_q, lane_d;
  logic [2:0]         wait_q, wait_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic [3:0]         en_a_q, en_a_d;
  logic [3:0]         en_b_q, en_b_d;
  logic [3:0]         en_add1_q, en_add1_d;
  logic [3:0]         en_f_q, en_f_d;
  logic               save_c_q, save_c_d;
  logic               done_q, done_d;
`ifdef DPCTRL_ADD2_EN
  logic [3:0]         en_add2_q, en_add2_d;
`endif

  logic       load_state;
  logic       accept;
  logic       lane_last;
  logic [3:0] lane_dec;

  assign load_state = (state_q == StLoadA) || (state_q == StLoadB) ||
                      (state_q == StLoadAdd1);
  // A beat offered during abort must not be consumed.
  assign s_ready    = load_state && !abort;
  assign accept     = s_valid && s_ready;
  assign lane_last  = (lane_q == 2'd3);
  assign lane_dec   = 4'b0001 << lane_q;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    wait_d    = wait_q;
    din_d     = din_q;
    en_a_d    = '0;
    en_b_d    = '0;
    en_add1_d = '0;
    en_f_d    = '0;
    save_c_d  = 1'b0;
    done_d    = 1'b0;
`ifdef DPCTRL_ADD2_EN
    en_add2_d = '0;
`endif
    if (abort) begin
      state_d = StIdle;
      lane_d  = '0;
      wait_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StLoadA;
            lane_d  = '0;
            wait_d  = '0;
          end
        end
        StLoadA: begin
          if (accept) begin
            din_d  = s_data;
            en_a_d = lane_dec;
            lane_d = lane_q + 2'd1;
            if (lane_last) state_d = StLoadB;
          end
        end
        StLoadB: begin
          if (accept) begin
            din_d  = s_data;
            en_b_d = lane_dec;
            lane_d = lane_q + 2'd1;
            if (lane_last) begin
              state_d = StMul;
              wait_d  = '0;
            end
          end
        end
        StMul: begin
          // wait_q == 0 is the capture cycle; the lane advances once the
          // post-capture idle count reaches MUL_WAIT (same cycle if zero).
          if (wait_q == '0) begin
            save_c_d = 1'b1;
            en_a_d   = lane_dec;
          end
          if (wait_q == MulWaitC) begin
            wait_d = '0;
            lane_d = lane_q + 2'd1;
            if (lane_last) state_d = StLoadAdd1;
          end else begin
            wait_d = wait_q + 3'd1;
          end
        end
        StLoadAdd1: begin
          if (accept) begin
            din_d     = s_data;
            en_add1_d = lane_dec;
            lane_d    = lane_q + 2'd1;
`ifdef DPCTRL_ADD2_EN
            if (lane_last) state_d = StAdd2;
`else
            if (lane_last) state_d = StWrite;
`endif
          end
        end
`ifdef DPCTRL_ADD2_EN
        StAdd2: begin
          en_add2_d = lane_dec;
          lane_d    = lane_q + 2'd1;
          if (lane_last) state_d = StWrite;
        end
`endif
        StWrite: begin
          en_f_d = lane_dec;
          lane_d = lane_q + 2'd1;
          if (lane_last) state_d = StDone;
        end
        StDone: begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          lane_d  = '0;
          wait_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      lane_q    <= '0;
      wait_q    <= '0;
      din_q     <= '0;
      en_a_q    <= '0;
      en_b_q    <= '0;
      en_add1_q <= '0;
      en_f_q    <= '0;
      save_c_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef DPCTRL_ADD2_EN
      en_add2_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      wait_q    <= wait_d;
      din_q     <= din_d;
      en_a_q    <= en_a_d;
      en_b_q    <= en_b_d;
      en_add1_q <= en_add1_d;
      en_f_q    <= en_f_d;
      save_c_q  <= save_c_d;
      done_q    <= done_d;
`ifdef DPCTRL_ADD2_EN
      en_add2_q <= en_add2_d;
`endif
    end
  end

  assign din       = din_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign lane      = lane_q;
  assign save_c    = save_c_q;
  assign en_a1     = en_a_q[0];
  assign en_a2     = en_a_q[1];
  assign en_a3     = en_a_q[2];
  assign en_a4     = en_a_q[3];
  assign en_b1     = en_b_q[0];
  assign en_b2     = en_b_q[1];
  assign en_b3     = en_b_q[2];
  assign en_b4     = en_b_q[3];
  assign en_add1_1 = en_add1_q[0];
  assign en_add1_2 = en_add1_q[1];
  assign en_add1_3 = en_add1_q[2];
  assign en_add1_4 = en_add1_q[3];
  assign en_f1     = en_f_q[0];
  assign en_f2     = en_f_q[1];
  assign en_f3     = en_f_q[2];
  assign en_f4     = en_f_q[3];
`ifdef DPCTRL_ADD2_EN
  assign en_add2_1 = en_add2_q[0];
  assign en_add2_2 = en_add2_q[1];
  assign en_add2_3 = en_add2_q[2];
  assign en_add2_4 = en_add2_q[3];
`else
  assign en_add2_1 = 1'b0;
  assign en_add2_2 = 1'b0;
  assign en_add2_3 = 1'b0;
  assign en_add2_4 = 1'b0;
`endif

endmodule
